// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART: register map, STATUS/CTRL
// bit positions, serial FSM state encodings and a small saturation helper.
package uart_pkg;

    // Register offsets, selected by address bits [3:2]
    localparam logic [1:0] REG_CLK_DIV = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_NOT_FULL = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_BUSY     = 3;
    localparam int ST_ERR_LSB     = 4;

    // CTRL bit positions (writable byte)
    localparam int CT_PAR_EN  = 0;
    localparam int CT_PAR_ODD = 1;
    localparam int CT_STOP2   = 2;
    localparam int CT_RX_IE   = 3;
    localparam int CT_TX_IE   = 4;
    localparam int CT_ERR_IE  = 5;

    // Sticky error flag positions inside the 4-bit error vector (STATUS[7:4])
    localparam int ERR_RX_OVF = 0;
    localparam int ERR_FRAME  = 1;
    localparam int ERR_PARITY = 2;
    localparam int ERR_TX_OVF = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Clamp a fill count to the 8-bit level fields of CTRL
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read port. A pop on empty is ignored;
// a push on full is accepted only when a pop frees an entry in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Accept/advance decisions and next pointer/count values
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers define which entries are valid.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped 8-bit UART with RX/TX FIFOs, optional parity, 1/2 stop bits,
// sticky W1C error flags and a registered, maskable level interrupt.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int          RX_DEPTH     = 16,
    parameter int          TX_DEPTH     = 16,
    parameter logic [15:0] DIV_RESET    = 16'd0,
    parameter int          RX_IRQ_LEVEL = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_in,
    output logic        tx_out,
    output logic        irq_out,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out
);

    localparam int RX_LW = $clog2(RX_DEPTH) + 1;
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;
    localparam logic [RX_LW-1:0] RX_IRQ_LVL = RX_LW'(RX_IRQ_LEVEL);

    // Register file
    logic [15:0] clk_div_q, clk_div_d;
    logic [5:0]  ctrl_q, ctrl_d;
    logic [3:0]  err_q, err_d;
    logic        irq_q, irq_d;

    // Bus decode
    logic [1:0]  reg_sel;
    logic        wr_en, rd_en;
    logic [7:0]  status_w;

    // FIFO handshakes
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]        rx_head;
    logic [RX_LW-1:0]  rx_level;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]        tx_head;
    logic [TX_LW-1:0]  tx_level;

    // Serial engines
    logic        rx_meta_q, rx_sync_q;
    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_par_en_q, tx_parity_q, tx_stop2_q, tx_stop_second_q, tx_out_q;
    logic        tx_bit_done, tx_frame_end, tx_busy, tx_ovf_set;

    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [7:0]  rx_shift_q;
    logic [2:0]  rx_bit_q;
    logic        rx_par_en_q, rx_par_odd_q, rx_par_bit_q;
    logic        rx_bit_done, rx_stop_sample, rx_par_bad;
    logic        frame_err_set, par_err_set, rx_ovf_set;

    logic        unused_bits;

    assign reg_sel   = address_in[3:2];
    assign wr_en     = sel_in && !read_in;
    assign rd_en     = sel_in && read_in;
    assign ready_out = sel_in;
    assign tx_out    = tx_out_q;
    assign irq_out   = irq_q;
    assign unused_bits = ^{address_in[31:4], address_in[1:0], write_value_in[31:16], write_mask_in[3:2]};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rx_push),
        .push_data (rx_shift_q),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_push),
        .push_data (write_value_in[7:0]),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    // TX side: a frame ends after the last stop period; the next byte is
    // popped in that same cycle so back-to-back frames have no idle gap.
    assign tx_bit_done  = (tx_cnt_q == 16'd0);
    assign tx_frame_end = (tx_state_q == TX_STOP) && tx_bit_done && (!tx_stop2_q || tx_stop_second_q);
    assign tx_pop       = ((tx_state_q == TX_IDLE) || tx_frame_end) && !tx_empty;
    assign tx_busy      = (tx_state_q != TX_IDLE);
    assign tx_push      = wr_en && (reg_sel == REG_DATA) && write_mask_in[0];
    assign tx_ovf_set   = tx_push && tx_full && !tx_pop;

    // RX side: the frame verdict is taken when the first stop bit is sampled
    assign rx_bit_done    = (rx_cnt_q == 16'd0);
    assign rx_stop_sample = (rx_state_q == RX_STOP) && rx_bit_done;
    assign rx_par_bad     = rx_par_en_q && (rx_par_bit_q != (^rx_shift_q ^ rx_par_odd_q));
    assign frame_err_set  = rx_stop_sample && !rx_sync_q;
    assign par_err_set    = rx_stop_sample && rx_sync_q && rx_par_bad;
    assign rx_push        = rx_stop_sample && rx_sync_q && !rx_par_bad;
    assign rx_pop         = rd_en && (reg_sel == REG_DATA) && !rx_empty;
    assign rx_ovf_set     = rx_push && rx_full && !rx_pop;

    // Register writes, sticky error flags (hardware set beats W1C) and irq
    always_comb begin
        clk_div_d = clk_div_q;
        ctrl_d    = ctrl_q;
        err_d     = err_q;
        if (wr_en) begin
            case (reg_sel)
                REG_CLK_DIV: begin
                    if (write_mask_in[0]) clk_div_d[7:0]  = write_value_in[7:0];
                    if (write_mask_in[1]) clk_div_d[15:8] = write_value_in[15:8];
                end
                REG_STATUS: begin
                    if (write_mask_in[0]) err_d = err_q & ~write_value_in[7:4];
                end
                REG_CTRL: begin
                    if (write_mask_in[0]) ctrl_d = write_value_in[5:0];
                end
                default: ;
            endcase
        end
        err_d[ERR_RX_OVF] = err_d[ERR_RX_OVF] | rx_ovf_set;
        err_d[ERR_FRAME]  = err_d[ERR_FRAME]  | frame_err_set;
        err_d[ERR_PARITY] = err_d[ERR_PARITY] | par_err_set;
        err_d[ERR_TX_OVF] = err_d[ERR_TX_OVF] | tx_ovf_set;
        irq_d = (ctrl_q[CT_RX_IE]  && (rx_level >= RX_IRQ_LVL))
              | (ctrl_q[CT_TX_IE]  && tx_empty && !tx_busy)
              | (ctrl_q[CT_ERR_IE] && (|err_q));
    end

    // Register file and interrupt flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_div_q <= DIV_RESET;
            ctrl_q    <= '0;
            err_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            clk_div_q <= clk_div_d;
            ctrl_q    <= ctrl_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
        end
    end

    // Combinational read mux; zero whenever no access is in progress
    always_comb begin
        status_w                  = '0;
        status_w[ST_TX_NOT_FULL]  = !tx_full;
        status_w[ST_RX_NOT_EMPTY] = !rx_empty;
        status_w[ST_TX_EMPTY]     = tx_empty;
        status_w[ST_TX_BUSY]      = tx_busy;
        status_w[ST_ERR_LSB+3:ST_ERR_LSB] = err_q;
        read_value_out = '0;
        if (sel_in) begin
            case (reg_sel)
                REG_CLK_DIV: read_value_out = {16'h0000, clk_div_q};
                REG_STATUS:  read_value_out = {24'h000000, status_w};
                REG_DATA:    read_value_out = {{24{rx_empty}}, rx_empty ? 8'h00 : rx_head};
                REG_CTRL:    read_value_out = {8'h00, sat8(32'(tx_level)), sat8(32'(rx_level)), 2'b00, ctrl_q};
                default:     read_value_out = '0;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input (idles high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    // TX frame sequencer; frame options are captured when a byte is popped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q       <= TX_IDLE;
            tx_cnt_q         <= '0;
            tx_shift_q       <= '0;
            tx_bit_q         <= '0;
            tx_par_en_q      <= 1'b0;
            tx_parity_q      <= 1'b0;
            tx_stop2_q       <= 1'b0;
            tx_stop_second_q <= 1'b0;
            tx_out_q         <= 1'b1;
        end else if (tx_pop) begin
            tx_state_q       <= TX_START;
            tx_cnt_q         <= clk_div_q;
            tx_shift_q       <= tx_head;
            tx_bit_q         <= '0;
            tx_par_en_q      <= ctrl_q[CT_PAR_EN];
            tx_parity_q      <= ^tx_head ^ ctrl_q[CT_PAR_ODD];
            tx_stop2_q       <= ctrl_q[CT_STOP2];
            tx_stop_second_q <= 1'b0;
            tx_out_q         <= 1'b0;
        end else if (tx_state_q != TX_IDLE) begin
            if (!tx_bit_done) begin
                tx_cnt_q <= tx_cnt_q - 16'd1;
            end else begin
                tx_cnt_q <= clk_div_q;
                case (tx_state_q)
                    TX_START: begin
                        tx_state_q <= TX_DATA;
                        tx_out_q   <= tx_shift_q[0];
                    end
                    TX_DATA: begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP;
                            tx_out_q   <= tx_par_en_q ? tx_parity_q : 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_out_q   <= tx_shift_q[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state_q <= TX_STOP;
                        tx_out_q   <= 1'b1;
                    end
                    TX_STOP: begin
                        if (tx_frame_end) begin
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_stop_second_q <= 1'b1;
                        end
                    end
                    default: begin
                        tx_state_q <= TX_IDLE;
                        tx_out_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    // RX frame sequencer; mid-bit sampling starting half a period into START
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_shift_q   <= '0;
            rx_bit_q     <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bit_q <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q   <= RX_START;
                        rx_cnt_q     <= clk_div_q >> 1;
                        rx_par_en_q  <= ctrl_q[CT_PAR_EN];
                        rx_par_odd_q <= ctrl_q[CT_PAR_ODD];
                    end
                end
                RX_START: begin
                    if (!rx_bit_done) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else if (rx_sync_q) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_state_q <= RX_DATA;
                        rx_cnt_q   <= clk_div_q;
                        rx_bit_q   <= '0;
                    end
                end
                RX_DATA: begin
                    if (!rx_bit_done) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= clk_div_q;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (!rx_bit_done) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        rx_par_bit_q <= rx_sync_q;
                        rx_state_q   <= RX_STOP;
                        rx_cnt_q     <= clk_div_q;
                    end
                end
                RX_STOP: begin
                    if (!rx_bit_done) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl with byte/bit scoreboards.
module tb_uart_fifo_ctrl;

    localparam logic [31:0] A_DIV    = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_DATA   = 32'h8;
    localparam logic [31:0] A_CTRL   = 32'hC;
    localparam int          BIT_CLKS = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_in = 1'b1;
    logic        tx_out;
    logic        irq_out;
    logic [31:0] address_in = '0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] write_value_in = '0;
    logic        ready_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_exp_q[$];
    logic       tx_exp_q[$];

    uart_fifo_ctrl #(
        .RX_DEPTH     (16),
        .TX_DEPTH     (16),
        .DIV_RESET    (16'd0),
        .RX_IRQ_LEVEL (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_in          (rx_in),
        .tx_out         (tx_out),
        .irq_out        (irq_out),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        sel_in = 1'b1; read_in = 1'b0; address_in = a; write_mask_in = m; write_value_in = d;
        @(negedge clk);
        sel_in = 1'b0; write_mask_in = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sel_in = 1'b1; read_in = 1'b1; address_in = a; write_mask_in = '0;
        #1 d = read_value_out;
        @(negedge clk);
        sel_in = 1'b0; read_in = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // Drive one serial frame at BIT_CLKS clocks per bit, then idle the line
    task automatic send_frame(input logic [7:0] data, input logic use_par,
                              input logic par_val, input logic stop_val);
        rx_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (use_par) begin
            rx_in = par_val;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_in = stop_val;
        repeat (BIT_CLKS) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    // Expected per-clock tx_out waveform for one 8N1 frame
    task automatic expect_tx_frame(input logic [7:0] b);
        repeat (BIT_CLKS) tx_exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (BIT_CLKS) tx_exp_q.push_back(b[i]);
        repeat (BIT_CLKS) tx_exp_q.push_back(1'b1);
    endtask

    task automatic read_data_expect(input string tag);
        logic [31:0] v;
        logic [7:0]  e;
        e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
        bus_read(A_DATA, v);
        check(tag, v, {24'h000000, e});
    endtask

    initial begin
        logic [31:0] v;
        logic        found;
        logic        exp_bit;
        int          n_tx;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_irq", irq_out, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        read_check("rst_status", A_STATUS, 32'h05);
        read_check("rst_div", A_DIV, 32'h0);
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("empty_data", A_DATA, 32'hFFFF_FF00);
        sel_in = 1'b1; read_in = 1'b1; address_in = A_DIV;
        #1 check("ready_hi", ready_out, 1'b1);
        sel_in = 1'b0;
        #1 check("ready_lo", ready_out, 1'b0);
        check("rdata_nosel", read_value_out, 32'h0);
        read_in = 1'b0;
        @(negedge clk);

        // 4 clocks per bit
        bus_write(A_DIV, 4'b0011, 32'h0000_0003);
        read_check("div_rb", A_DIV, 32'h3);

        // TX: two back-to-back frames, checked every clock
        expect_tx_frame(8'h55);
        expect_tx_frame(8'hA3);
        n_tx = tx_exp_q.size();
        bus_write(A_DATA, 4'b0001, 32'h55);
        bus_write(A_DATA, 4'b0001, 32'hA3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tx_out === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        check("tx_start_seen", found, 1'b1);
        for (int i = 0; i < n_tx; i++) begin
            exp_bit = tx_exp_q.pop_front();
            check($sformatf("tx_wave[%0d]", i), tx_out, exp_bit);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("tx_idle_line", tx_out, 1'b1);
        read_check("tx_done_status", A_STATUS, 32'h05);

        // RX single byte
        rx_exp_q.push_back(8'h6C);
        send_frame(8'h6C, 1'b0, 1'b0, 1'b1);
        bus_read(A_STATUS, v);
        check("rx_not_empty", {31'b0, v[1]}, 32'd1);
        read_data_expect("rx_6c");
        read_check("rx_then_empty", A_DATA, 32'hFFFF_FF00);

        // Parity error, W1C, then a good parity frame
        bus_write(A_CTRL, 4'b0001, 32'h01);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        read_check("par_err_status", A_STATUS, 32'h45);
        bus_write(A_STATUS, 4'b0001, 32'h40);
        read_check("par_err_clr", A_STATUS, 32'h05);
        rx_exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        read_data_expect("par_ok_byte");
        bus_write(A_CTRL, 4'b0001, 32'h00);

        // RX overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i * 13 + 5);
            if (i < 16) rx_exp_q.push_back(b);
            send_frame(b, 1'b0, 1'b0, 1'b1);
        end
        read_check("ovf_level", A_CTRL, 32'h0000_1000);
        read_check("ovf_status", A_STATUS, 32'h17);
        for (int i = 0; i < 16; i++) read_data_expect($sformatf("ovf_byte[%0d]", i));
        bus_write(A_STATUS, 4'b0001, 32'h10);
        read_check("ovf_clr", A_STATUS, 32'h05);

        // Framing error
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        read_check("frame_err", A_STATUS, 32'h25);
        bus_write(A_STATUS, 4'b0001, 32'h20);
        read_check("frame_clr", A_STATUS, 32'h05);

        // One-clock glitch on an idle line
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        read_check("glitch_status", A_STATUS, 32'h05);
        read_check("glitch_data", A_DATA, 32'hFFFF_FF00);

        // RX interrupt at level 2
        bus_write(A_CTRL, 4'b0001, 32'h08);
        read_check("ctrl_rx_ie", A_CTRL, 32'h08);
        check("irq_lvl0", irq_out, 1'b0);
        rx_exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        check("irq_lvl1", irq_out, 1'b0);
        rx_exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("irq_lvl2", irq_out, 1'b1);
        read_data_expect("irq_pop1");
        repeat (2) @(negedge clk);
        check("irq_after_pop", irq_out, 1'b0);
        read_data_expect("irq_pop2");
        bus_write(A_CTRL, 4'b0001, 32'h00);

        // TX overflow: 18 back-to-back writes of 0x00
        for (int i = 0; i < 18; i++) bus_write(A_DATA, 4'b0001, 32'h00);
        read_check("tx_level", A_CTRL, 32'h0010_0000);
        read_check("tx_ovf_status", A_STATUS, 32'h88);
        check("tx_mid_frame_low", tx_out, 1'b0);

        // Asynchronous reset mid-frame
        reset_n = 1'b0;
        #1 check("rst_async_tx", tx_out, 1'b1);
        check("rst_async_irq", irq_out, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_check("post_rst_status", A_STATUS, 32'h05);
        read_check("post_rst_div", A_DIV, 32'h0);
        read_check("post_rst_ctrl", A_CTRL, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
